// File: rtl/noc_link_pipe.sv
// noc_link_pipe
//   Elastic, fully registered pipeline stage for a NoC flit link. Flit, valid
//   and tail sideband are registered in the forward direction. The stall is
//   registered in the backward direction. A main + skid buffer pair sustains
//   one flit per cycle with no bubbles. The block also counts delivered flits
//   and tail flits, and flags upstream protocol violations.
//
// Ports
//   clk, rst                   link clock, synchronous active-high reset
//   FLIT_in/VALID_in/FWDAUX1_in  upstream flit, valid, tail marker
//   BWDAUX1_out                stall to upstream (skid occupied)
//   BWDAUX2_out/BWDAUX3_out    backward sideband to upstream, one flop delay
//   FLIT_out/VALID_out/FWDAUX1_out  downstream flit, valid, tail marker
//   BWDAUX1_in                 stall from downstream
//   BWDAUX2_in/BWDAUX3_in      backward sideband from downstream
//   flit_count/pkt_count       wrapping delivered-flit / delivered-tail counts
//   overflow_err               sticky: flit presented while stalled
module noc_link_pipe #(
    parameter int FLIT_WIDTH = 80,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] FLIT_in,
    input  logic                  VALID_in,
    input  logic                  FWDAUX1_in,
    output logic                  BWDAUX1_out,
    output logic                  BWDAUX2_out,
    output logic                  BWDAUX3_out,
    output logic [FLIT_WIDTH-1:0] FLIT_out,
    output logic                  VALID_out,
    output logic                  FWDAUX1_out,
    input  logic                  BWDAUX1_in,
    input  logic                  BWDAUX2_in,
    input  logic                  BWDAUX3_in,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  overflow_err
);

    // State encoding is {main_v, skid_v}, so both valid bits and the stall
    // come straight off the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic                  skid_v;
    logic [FLIT_WIDTH-1:0] skid_flit;
    logic                  skid_tail;

    logic                  accept;
    logic                  deliver;
    logic                  violation;
    logic                  ld_main_in;
    logic                  ld_main_skid;
    logic                  ld_skid;

    assign VALID_out   = state[1];
    assign skid_v      = state[0];
    assign BWDAUX1_out = skid_v;

    assign accept    = VALID_in & ~BWDAUX1_out;
    assign deliver   = VALID_out & ~BWDAUX1_in;
    assign violation = VALID_in & BWDAUX1_out;

    // Next-state and buffer load selects. A violating flit is never accepted,
    // so it cannot disturb the stored flits.
    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    ld_main_in = 1'b1;
                    state_nxt  = ONE;
                end
            end
            ONE: begin
                if (deliver && accept) begin
                    ld_main_in = 1'b1;
                end else if (deliver) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    ld_skid   = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (deliver) begin
                    ld_main_skid = 1'b1;
                    state_nxt    = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Main register drives the outputs; it is cleared on reset so a reset
    // link shows an all-zero flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            FLIT_out    <= '0;
            FWDAUX1_out <= 1'b0;
        end else if (ld_main_in) begin
            FLIT_out    <= FLIT_in;
            FWDAUX1_out <= FWDAUX1_in;
        end else if (ld_main_skid) begin
            FLIT_out    <= skid_flit;
            FWDAUX1_out <= skid_tail;
        end
    end

    // Skid payload is only meaningful while skid_v is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ld_skid) begin
            skid_flit <= FLIT_in;
            skid_tail <= FWDAUX1_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            BWDAUX2_out <= 1'b0;
            BWDAUX3_out <= 1'b0;
        end else begin
            BWDAUX2_out <= BWDAUX2_in;
            BWDAUX3_out <= BWDAUX3_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_count   <= '0;
            pkt_count    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (deliver) begin
                flit_count <= flit_count + CNT_ONE;
                if (FWDAUX1_out) begin
                    pkt_count <= pkt_count + CNT_ONE;
                end
            end
            if (violation) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_link_pipe.sv
module tb_noc_link_pipe;

    localparam int FW = 80;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] FLIT_in;
    logic          VALID_in;
    logic          FWDAUX1_in;
    logic          BWDAUX1_in;
    logic          BWDAUX2_in;
    logic          BWDAUX3_in;

    logic          BWDAUX1_out, BWDAUX2_out, BWDAUX3_out;
    logic [FW-1:0] FLIT_out;
    logic          VALID_out, FWDAUX1_out;
    logic [15:0]   flit_count, pkt_count;
    logic          overflow_err;

    logic          s_bwd1, s_bwd2, s_bwd3;
    logic [FW-1:0] s_flit;
    logic          s_valid, s_tail;
    logic [3:0]    s_flit_count, s_pkt_count;
    logic          s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_link_pipe #(.FLIT_WIDTH(FW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .FLIT_in(FLIT_in), .VALID_in(VALID_in), .FWDAUX1_in(FWDAUX1_in),
        .BWDAUX1_out(BWDAUX1_out), .BWDAUX2_out(BWDAUX2_out), .BWDAUX3_out(BWDAUX3_out),
        .FLIT_out(FLIT_out), .VALID_out(VALID_out), .FWDAUX1_out(FWDAUX1_out),
        .BWDAUX1_in(BWDAUX1_in), .BWDAUX2_in(BWDAUX2_in), .BWDAUX3_in(BWDAUX3_in),
        .flit_count(flit_count), .pkt_count(pkt_count), .overflow_err(overflow_err)
    );

    // Narrow-counter copy driven by the same inputs, used for wrap checks.
    noc_link_pipe #(.FLIT_WIDTH(FW), .CNT_WIDTH(4)) dut_w4 (
        .clk(clk), .rst(rst),
        .FLIT_in(FLIT_in), .VALID_in(VALID_in), .FWDAUX1_in(FWDAUX1_in),
        .BWDAUX1_out(s_bwd1), .BWDAUX2_out(s_bwd2), .BWDAUX3_out(s_bwd3),
        .FLIT_out(s_flit), .VALID_out(s_valid), .FWDAUX1_out(s_tail),
        .BWDAUX1_in(BWDAUX1_in), .BWDAUX2_in(BWDAUX2_in), .BWDAUX3_in(BWDAUX3_in),
        .flit_count(s_flit_count), .pkt_count(s_pkt_count), .overflow_err(s_err)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with live-looking inputs, which must be ignored.
    task automatic do_reset(input int n);
        rst        = 1'b1;
        VALID_in   = 1'b1;
        FLIT_in    = 80'h55;
        FWDAUX1_in = 1'b1;
        BWDAUX2_in = 1'b1;
        BWDAUX3_in = 1'b1;
        repeat (n) step();
        rst        = 1'b0;
        VALID_in   = 1'b0;
        FWDAUX1_in = 1'b0;
        BWDAUX1_in = 1'b0;
        BWDAUX2_in = 1'b0;
        BWDAUX3_in = 1'b0;
    endtask

    logic [80:0] q[$];
    logic [80:0] exp_e;
    logic [95:0] r;
    int sent, delivered, tails, cyc;

    initial begin
        rst = 1'b0; VALID_in = 1'b0; FLIT_in = '0; FWDAUX1_in = 1'b0;
        BWDAUX1_in = 1'b0; BWDAUX2_in = 1'b0; BWDAUX3_in = 1'b0;
        @(negedge clk);

        // ---------------- reset ----------------
        do_reset(2);
        chk("rst_valid", VALID_out, 0);
        chk("rst_flit", FLIT_out, 0);
        chk("rst_tail", FWDAUX1_out, 0);
        chk("rst_stall", BWDAUX1_out, 0);
        chk("rst_bwd2", BWDAUX2_out, 0);
        chk("rst_bwd3", BWDAUX3_out, 0);
        chk("rst_fcnt", flit_count, 0);
        chk("rst_pcnt", pkt_count, 0);
        chk("rst_err", overflow_err, 0);

        // ---------------- streaming ----------------
        for (int i = 0; i <= 8; i++) begin
            if (i >= 1) begin
                chk("str_valid", VALID_out, 1);
                chk("str_flit", FLIT_out, i);
                chk("str_tail", FWDAUX1_out, (i == 4 || i == 8));
                chk("str_stall", BWDAUX1_out, 0);
            end
            if (i < 8) begin
                VALID_in   = 1'b1;
                FLIT_in    = 80'(i + 1);
                FWDAUX1_in = (i == 3 || i == 7);
            end else begin
                VALID_in   = 1'b0;
                FWDAUX1_in = 1'b0;
            end
            step();
        end
        chk("str_valid_end", VALID_out, 0);
        chk("str_fcnt", flit_count, 8);
        chk("str_pcnt", pkt_count, 2);

        // ---------------- backpressure ----------------
        do_reset(1);
        VALID_in = 1'b1; FLIT_in = 80'hA;
        step();
        chk("bp_a_out", FLIT_out, 80'hA);
        chk("bp_stall0", BWDAUX1_out, 0);
        BWDAUX1_in = 1'b1; VALID_in = 1'b1; FLIT_in = 80'hB;
        step();
        VALID_in = 1'b0; FLIT_in = 80'hC;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_flit", FLIT_out, 80'hA);
            chk("bp_hold_valid", VALID_out, 1);
            chk("bp_stall1", BWDAUX1_out, 1);
            step();
        end
        BWDAUX1_in = 1'b0;
        step();
        chk("bp_b_out", FLIT_out, 80'hB);
        chk("bp_b_valid", VALID_out, 1);
        chk("bp_release", BWDAUX1_out, 0);
        VALID_in = 1'b1; FLIT_in = 80'hC;
        step();
        VALID_in = 1'b0;
        chk("bp_c_out", FLIT_out, 80'hC);
        chk("bp_c_valid", VALID_out, 1);
        step();
        chk("bp_empty", VALID_out, 0);
        chk("bp_fcnt", flit_count, 3);

        // ---------------- violation ----------------
        do_reset(1);
        BWDAUX1_in = 1'b1;
        VALID_in = 1'b1; FLIT_in = 80'h11;
        step();
        FLIT_in = 80'h22;
        step();
        chk("vio_stall", BWDAUX1_out, 1);
        chk("vio_err_pre", overflow_err, 0);
        FLIT_in = 80'hDEAD;
        step();
        VALID_in = 1'b0;
        chk("vio_err", overflow_err, 1);
        chk("vio_main", FLIT_out, 80'h11);
        BWDAUX1_in = 1'b0;
        step();
        chk("vio_skid", FLIT_out, 80'h22);
        chk("vio_skid_valid", VALID_out, 1);
        step();
        chk("vio_empty", VALID_out, 0);
        chk("vio_fcnt", flit_count, 2);
        chk("vio_sticky", overflow_err, 1);

        // ---------------- reset in FULL ----------------
        BWDAUX1_in = 1'b1;
        VALID_in = 1'b1; FLIT_in = 80'h33;
        step();
        FLIT_in = 80'h44;
        step();
        chk("full_stall", BWDAUX1_out, 1);
        do_reset(1);
        chk("full_rst_valid", VALID_out, 0);
        chk("full_rst_stall", BWDAUX1_out, 0);
        chk("full_rst_err", overflow_err, 0);
        step();
        chk("full_rst_drained", VALID_out, 0);

        // ---------------- sideband ----------------
        BWDAUX2_in = 1'b1;
        chk("sb2_pre", BWDAUX2_out, 0);
        step();
        BWDAUX2_in = 1'b0; BWDAUX3_in = 1'b1;
        chk("sb2_pulse", BWDAUX2_out, 1);
        chk("sb3_pre", BWDAUX3_out, 0);
        step();
        BWDAUX3_in = 1'b0;
        chk("sb2_end", BWDAUX2_out, 0);
        chk("sb3_pulse", BWDAUX3_out, 1);
        step();
        chk("sb3_end", BWDAUX3_out, 0);

        // ---------------- counter wrap (4-bit copy) ----------------
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            VALID_in = 1'b1; FLIT_in = 80'(i + 100); FWDAUX1_in = 1'b1;
            step();
            chk("wrap_flit", FLIT_out, i + 100);
        end
        VALID_in = 1'b0; FWDAUX1_in = 1'b0;
        step();
        chk("wrap_fcnt16", flit_count, 17);
        chk("wrap_fcnt4", s_flit_count, 1);
        chk("wrap_pcnt4", s_pkt_count, 1);

        // ---------------- random stalls, scoreboard ----------------
        do_reset(1);
        sent = 0; delivered = 0; tails = 0; cyc = 0;
        while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
            BWDAUX1_in = ($urandom_range(0, 9) < 3);
            if (sent < 10000 && !BWDAUX1_out && $urandom_range(0, 9) < 7) begin
                r = {$urandom, $urandom, $urandom};
                VALID_in   = 1'b1;
                FLIT_in    = r[79:0];
                FWDAUX1_in = r[80];
            end else begin
                VALID_in   = 1'b0;
                FWDAUX1_in = 1'b0;
            end
            if (VALID_out && !BWDAUX1_in) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    exp_e = q.pop_front();
                    chk("rnd_flit", {FWDAUX1_out, FLIT_out}, exp_e);
                    delivered++;
                    if (exp_e[80]) tails++;
                end
            end
            if (VALID_in) begin
                q.push_back({FWDAUX1_in, FLIT_in});
                sent++;
            end
            step();
            cyc++;
        end
        VALID_in = 1'b0; BWDAUX1_in = 1'b0;
        chk("rnd_done", (cyc < 60000), 1);
        chk("rnd_err", overflow_err, 0);
        chk("rnd_fcnt", flit_count, delivered[15:0]);
        chk("rnd_pcnt", pkt_count, tails[15:0]);
        chk("rnd_fcnt4", s_flit_count, delivered[3:0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
